// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit path.
//   UART_DATA_WIDTH    - width of one transmitted character (bits)
//   UART_TX_FIFO_DEPTH - default number of entries in the transmit FIFO
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x UART_DATA_WIDTH storage for the transmit FIFO.
// One synchronous write port and one asynchronous (combinational) read port,
// so the byte at the read pointer is visible in the same cycle it is addressed.
// Contents are deliberately not reset; validity is tracked by the pointers.
//   clock   - write clock
//   we_i    - write strobe
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from raddr_i)
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [UART_DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]              raddr_i,
  output logic [UART_DATA_WIDTH-1:0] rdata_o
);

  logic [UART_DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter, show-ahead read side.
//   clock       - rising-edge clock
//   resetN      - asynchronous active-low reset
//   clear       - synchronous flush (pointers, level, overflow)
//   writeEnable - push request; writeData - byte to push
//   full        - level == DEPTH
//   almostFull  - level >= AF_LEVEL
//   level       - number of stored bytes, 0..DEPTH
//   overflow    - sticky, set when a push is dropped because the FIFO is full
//   fifoData    - oldest byte while fifoEmpty is low, 8'h00 otherwise
//   fifoEmpty   - no stored byte
//   fifoReadAck - pop pulse from the transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_TX_FIFO_DEPTH,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       clear,
  input  logic                       writeEnable,
  input  logic [UART_DATA_WIDTH-1:0] writeData,
  output logic                       full,
  output logic                       almostFull,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [UART_DATA_WIDTH-1:0] fifoData,
  output logic                       fifoEmpty,
  input  logic                       fifoReadAck
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;   // pointers carry an extra wrap bit

  localparam cnt_t ONE       = cnt_t'(1);
  localparam cnt_t DEPTH_LVL = cnt_t'(DEPTH);
  localparam cnt_t AF_LVL    = cnt_t'(AF_LEVEL);

  cnt_t wr_ptr_q, wr_ptr_d;
  cnt_t rd_ptr_q, rd_ptr_d;
  cnt_t level_q,  level_d;
  logic full_q,   full_d;
  logic empty_q,  empty_d;
  logic af_q,     af_d;
  logic ovf_q,    ovf_d;

  logic                       push_acc;
  logic                       pop_acc;
  logic                       mem_we;
  logic [UART_DATA_WIDTH-1:0] mem_rdata;

  // A pop is only real when something is stored. A push into a full FIFO is
  // still accepted when a pop frees the slot in the same cycle; the write then
  // lands in the slot being read out, which is safe because the read is
  // combinational and the write happens at the edge.
  assign pop_acc  = fifoReadAck & ~empty_q;
  assign push_acc = writeEnable & (~full_q | pop_acc);
  assign mem_we   = push_acc & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE;
      unique case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + ONE;
        2'b01:   level_d = level_q - ONE;
        default: level_d = level_q;
      endcase
      if (writeEnable && full_q && !pop_acc) ovf_d = 1'b1;
    end
    // Flags are derived from the next level and registered with it.
    full_d  = (level_d == DEPTH_LVL);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_LVL);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (writeData),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign full       = full_q;
  assign almostFull = af_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign fifoEmpty  = empty_q;
  // Gated by the registered empty flag so reset blanks the output at once.
  assign fifoData   = empty_q ? '0 : mem_rdata;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          clear = 1'b0;
  logic          writeEnable = 1'b0;
  logic [7:0]    writeData = 8'h00;
  logic          fifoReadAck = 1'b0;
  logic          full;
  logic          almostFull;
  logic [LW-1:0] level;
  logic          overflow;
  logic [7:0]    fifoData;
  logic          fifoEmpty;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .clear       (clear),
    .writeEnable (writeEnable),
    .writeData   (writeData),
    .full        (full),
    .almostFull  (almostFull),
    .level       (level),
    .overflow    (overflow),
    .fifoData    (fifoData),
    .fifoEmpty   (fifoEmpty),
    .fifoReadAck (fifoReadAck)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_state(input string tag, input int lvl, input int full_e,
                             input int empty_e, input int af_e, input int ovf_e,
                             input int data_e);
    check({tag, ".level"},      int'(level),      lvl);
    check({tag, ".full"},       int'(full),       full_e);
    check({tag, ".fifoEmpty"},  int'(fifoEmpty),  empty_e);
    check({tag, ".almostFull"}, int'(almostFull), af_e);
    check({tag, ".overflow"},   int'(overflow),   ovf_e);
    check({tag, ".fifoData"},   int'(fifoData),   data_e);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 time unit after the following edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic ra,
                      input logic clr);
    writeEnable = we;
    writeData   = wd;
    fifoReadAck = ra;
    clear       = clr;
    @(posedge clock);
    #1;
    writeEnable = 1'b0;
    fifoReadAck = 1'b0;
    clear       = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       we;
    logic [7:0] wd;
    logic       ra;
    logic       clr;
    int         lvl;
    int         empty_e;
    int         data_e;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int nb;

    // Vectors start from the reset state; full/almostFull/overflow stay 0.
    vecs[0] = '{"push41",        1'b1, 8'h41, 1'b0, 1'b0, 1, 0, 'h41};
    vecs[1] = '{"pop41",         1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 'h00};
    vecs[2] = '{"pop_on_empty",  1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 'h00};
    vecs[3] = '{"pushpop_empty", 1'b1, 8'h55, 1'b1, 1'b0, 1, 0, 'h55};
    vecs[4] = '{"push66",        1'b1, 8'h66, 1'b0, 1'b0, 2, 0, 'h55};
    vecs[5] = '{"pushpop_mid",   1'b1, 8'h77, 1'b1, 1'b0, 2, 0, 'h66};
    vecs[6] = '{"pop66",         1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 'h77};
    vecs[7] = '{"clear_prio",    1'b1, 8'h88, 1'b1, 1'b1, 0, 1, 'h00};

    // Reset state while resetN is held low.
    repeat (2) @(posedge clock);
    #1;
    check_state("reset", 0, 0, 1, 0, 0, 'h00);
    resetN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].ra, vecs[i].clr);
      check_state(vecs[i].name, vecs[i].lvl, 0, vecs[i].empty_e, 0, 0, vecs[i].data_e);
      $display("vec %0d %s: level=%0d empty=%0d data=0x%02h", i, vecs[i].name,
               level, fifoEmpty, fifoData);
    end

    // Fill to full, watching almostFull and full thresholds.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill.level", int'(level), i + 1);
      check("fill.almostFull", int'(almostFull), (i + 1 >= AF) ? 1 : 0);
      check("fill.full", int'(full), (i + 1 == DEPTH) ? 1 : 0);
    end
    $display("filled: level=%0d full=%0d almostFull=%0d", level, full, almostFull);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check_state("push_when_full", 16, 1, 0, 1, 1, 'h00);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.data", int'(fifoData), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_state("drained", 0, 0, 1, 0, 1, 'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_state("clear_ovf", 0, 0, 1, 0, 0, 'h00);

    // Push with simultaneous pop while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check_state("full_pushpop", 16, 1, 0, 1, 0, 'h11);
    for (int i = 0; i < DEPTH; i++) begin
      check("full_pushpop.data", int'(fifoData), (i < DEPTH - 1) ? (8'h11 + i) : 8'hAA);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("full_pushpop.empty", int'(fifoEmpty), 1);
    $display("full push+pop sequence done: level=%0d overflow=%0d", level, overflow);

    // Interleaved traffic at level 1..3 across pointer wrap.
    nb = 8'hC0;
    step(1'b1, 8'(nb), 1'b0, 1'b0);
    q.push_back(8'(nb));
    nb++;
    for (int k = 0; k < 40; k++) begin
      automatic int  ph      = k % 5;
      automatic bit  do_push = (ph <= 2);
      automatic bit  do_pop  = (ph >= 2);
      if (do_pop) check("wrap.data", int'(fifoData), int'(q[0]));
      step(do_push, 8'(nb), do_pop, 1'b0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(8'(nb));
        nb++;
      end
      check("wrap.level", int'(level), q.size());
      $display("wrap %0d: push=%0d pop=%0d level=%0d", k, do_push, do_pop, level);
    end

    // Asynchronous reset in the middle of a cycle.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("prereset.level", int'(level), 5);
    #2;
    resetN = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 1, 0, 0, 'h00);
    #1;
    resetN = 1'b1;
    @(posedge clock);
    #1;
    check_state("after_release", 0, 0, 1, 0, 0, 'h00);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check_state("push_after_reset", 1, 0, 0, 0, 0, 'h77);
    $display("async reset sequence done: level=%0d data=0x%02h", level, fifoData);

    // Sticky overflow, then clear beats a concurrent push.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check_state("ovf_set", 16, 1, 0, 1, 1, 'h60);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("ovf_sticky", 15, 0, 0, 1, 1, 'h61);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    check_state("clear_with_push", 0, 0, 1, 0, 0, 'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_state("clear_idle", 0, 0, 1, 0, 0, 'h00);
    $display("clear sequence done: level=%0d overflow=%0d", level, overflow);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AF_LEVEL, default 12, level at or above which almostFull asserts; SHALL satisfy 1 <= AF_LEVEL <= DEPTH.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous flush of all entries and overflow flag.
REQ-007 writeEnable  input  1  push request, one byte per asserted cycle.
REQ-008 writeData  input  8  byte to push.
REQ-009 full  output  1  no free entry.
REQ-010 almostFull  output  1  level >= AF_LEVEL.
REQ-011 level  output  log2(DEPTH)+1  number of stored bytes, 0..DEPTH.
REQ-012 overflow  output  1  sticky: a push was attempted while full.
REQ-013 fifoData  output  8  show-ahead oldest byte, valid while fifoEmpty is low.
REQ-014 fifoEmpty  output  1  no stored byte.
REQ-015 fifoReadAck  input  1  transmitter pop pulse, one byte per asserted cycle.

Function
REQ-016 Storage SHALL be a DEPTH x 8 register array with read and write pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-017 Push accepted when writeEnable=1 and full=0: byte written at the write pointer, pointer incremented modulo 2*DEPTH at the clock edge.
REQ-018 Pop accepted when fifoReadAck=1 and fifoEmpty=0: read pointer incremented at the clock edge; the popped byte is not otherwise altered.
REQ-019 fifoReadAck while fifoEmpty=1 SHALL be ignored: no pointer change, no flag.
REQ-020 writeEnable while full=1 without a simultaneous accepted pop SHALL be dropped and SHALL set overflow at the same edge.
REQ-021 Simultaneous push and pop while full SHALL both be accepted; level stays DEPTH; overflow is not set.
REQ-022 Simultaneous push and pop while empty: push accepted, pop ignored; level becomes 1.
REQ-023 Simultaneous accepted push and pop at intermediate level: level unchanged; both pointers advance.
REQ-024 level, full, fifoEmpty, almostFull SHALL be registered and reflect all accepted operations one cycle after the edge on which they occur.
REQ-025 Write-to-read latency: a byte pushed into an empty FIFO at edge N SHALL appear on fifoData with fifoEmpty=0 after edge N, i.e. in cycle N+1.
REQ-026 fifoData SHALL be the entry at the read pointer while fifoEmpty=0, and 8'h00 while fifoEmpty=1.
REQ-027 full SHALL equal (level == DEPTH); fifoEmpty SHALL equal (level == 0).
REQ-028 clear=1 SHALL at the next edge zero both pointers, level and overflow, and SHALL take priority over concurrent push and pop.
REQ-029 overflow SHALL remain set until clear or reset.

Reset
REQ-030 resetN=0 SHALL immediately force: pointers 0, level 0, fifoEmpty 1, full 0, almostFull 0, overflow 0, fifoData 8'h00.
REQ-031 Storage array contents SHALL NOT be reset.
REQ-032 Reset asserted mid-operation discards all stored bytes; the first push after release behaves as a push into an empty FIFO.

Structure
REQ-033 Shared package uart_pkg SHALL hold UART_DATA_WIDTH (8) and UART_TX_FIFO_DEPTH default (16).
REQ-034 The storage array SHALL be one sub-module, uart_fifo_mem (one write port, one asynchronous read port, no reset); pointer and flag logic stays in uart_tx_fifo.

Verification
REQ-035 Reset, push 8'h41 -> next cycle fifoEmpty=0, fifoData=8'h41, level=1; pulse fifoReadAck -> next cycle fifoEmpty=1, fifoData=8'h00.
REQ-036 Push 16 bytes 8'h00..8'h0F, DEPTH=16 -> full=1, almostFull from level 12, level=16; 17th push dropped, overflow=1; pop all -> order 8'h00..8'h0F.
REQ-037 At full, push 8'hAA with simultaneous fifoReadAck -> level stays 16, overflow stays 0, 8'hAA read out last.
REQ-038 Wrap: 40 pushes/pops interleaved at level 1..3 -> data order preserved across pointer wrap, level never exceeds 3.
REQ-039 Fill to 5, assert resetN=0 mid-cycle -> outputs at reset values immediately without a clock edge; after release, fifoEmpty=1, level=0.
REQ-040 Set overflow, then clear=1 with writeEnable=1 -> next cycle level=0, overflow=0, fifoEmpty=1; the concurrent push is discarded.
